// File: rtl/fetch_stage_pkg.sv
// Shared encodings and defaults for the instruction-fetch stage.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,
    IF_HOLD  = 2'd1,
    IF_DROP  = 2'd2
  } if_state_e;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready bus between fetch and imem.
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load beats clear; otherwise holds.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= 32'h0;
      instr <= NOP_INSTR;
    end else if (flush) begin
      // PC is left as-is; only valid and the instruction word are squashed.
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the fetch PC, issues imem requests, skids one fetch under
// decode stall and squashes in-flight fetches on redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          npc,
  input  logic                 redirect,
  input  logic                 stall,
  output logic [31:0]          pc_out,
  output logic [31:0]          pcplus4,
  fetch_stage_if.master        imem,
  output logic                 id_valid,
  output logic [31:0]          id_pc,
  output logic [31:0]          id_instr
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sk_pc_q, sk_pc_d;
  logic [31:0] sk_instr_q, sk_instr_d;

  logic        req, hs, id_accepts;
  logic        id_load, id_flush, id_clear;
  logic [31:0] id_load_pc, id_load_instr;

  assign req        = (state_q != IF_HOLD);
  assign hs         = req & imem.ready;
  assign id_accepts = ~stall | ~id_valid;

  assign imem.req  = req;
  // An abandoned request keeps its address until the memory completes it.
  assign imem.addr = (state_q == IF_DROP) ? addr_q : pc_q;
  assign pc_out    = pc_q;
  assign pcplus4   = pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    addr_d        = addr_q;
    sk_pc_d       = sk_pc_q;
    sk_instr_d    = sk_instr_q;
    id_load       = 1'b0;
    id_flush      = 1'b0;
    id_clear      = 1'b0;
    id_load_pc    = pc_q;
    id_load_instr = imem.rdata;

    unique case (state_q)
      IF_FETCH: begin
        if (redirect) begin
          id_flush = 1'b1;
          pc_d     = npc;
          if (!hs) begin
            addr_d  = pc_q;
            state_d = IF_DROP;
          end
        end else if (hs && id_accepts) begin
          id_load = 1'b1;
          pc_d    = npc;
        end else if (hs) begin
          sk_pc_d    = pc_q;
          sk_instr_d = imem.rdata;
          pc_d       = npc;
          state_d    = IF_HOLD;
        end else if (id_accepts) begin
          id_clear = 1'b1;
        end
      end
      IF_HOLD: begin
        id_load_pc    = sk_pc_q;
        id_load_instr = sk_instr_q;
        if (redirect) begin
          id_flush = 1'b1;
          pc_d     = npc;
          state_d  = IF_FETCH;
        end else if (!stall) begin
          id_load = 1'b1;
          state_d = IF_FETCH;
        end
      end
      IF_DROP: begin
        id_clear = 1'b1;
        if (redirect) begin
          id_flush = 1'b1;
          pc_d     = npc;
        end else if (hs) begin
          state_d = IF_FETCH;
        end
      end
      default: state_d = IF_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IF_FETCH;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      sk_pc_q    <= 32'h0;
      sk_instr_q <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      sk_pc_q    <= sk_pc_d;
      sk_instr_q <= sk_instr_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (id_load),
    .flush      (id_flush),
    .clear      (id_clear),
    .load_pc    (id_load_pc),
    .load_instr (id_load_instr),
    .valid      (id_valid),
    .pc         (id_pc),
    .instr      (id_instr)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed test-plan sequence with literal pins, then
// random traffic checked each cycle against a queue-based reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] npc = 32'h0;
  logic        redirect = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] pc_out, pcplus4, id_pc, id_instr;
  logic        id_valid;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_stage_if bus ();

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  assign bus.rdata = mem(bus.addr);

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk      (clk),
    .rst      (rst),
    .npc      (npc),
    .redirect (redirect),
    .stall    (stall),
    .pc_out   (pc_out),
    .pcplus4  (pcplus4),
    .imem     (bus),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_instr (id_instr)
  );

  // Reference model: a fetch PC, an optional abandoned request, and a skid
  // queue holding at most one captured fetch.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic [31:0] m_pc, m_drop_addr, m_idpc, m_instr;
  logic        m_dropping, m_v;
  entry_t      skid[$];

  task automatic model_reset();
    m_pc        = 32'h0;
    m_drop_addr = 32'h0;
    m_dropping  = 1'b0;
    skid.delete();
    m_v         = 1'b0;
    m_idpc      = 32'h0;
    m_instr     = NOP;
  endtask

  task automatic model_step();
    logic   req, hs, acc;
    entry_t e;
    req = (skid.size() == 0);
    hs  = req && bus.ready;
    acc = !stall || !m_v;
    if (redirect) begin
      m_v     = 1'b0;
      m_instr = NOP;
      if (!m_dropping && skid.size() == 0 && !hs) begin
        m_dropping  = 1'b1;
        m_drop_addr = m_pc;
      end
      skid.delete();
      m_pc = npc;
    end else if (m_dropping) begin
      if (hs) m_dropping = 1'b0;
    end else if (skid.size() != 0) begin
      if (!stall) begin
        e       = skid.pop_front();
        m_v     = 1'b1;
        m_idpc  = e.pc;
        m_instr = e.instr;
      end
    end else if (hs) begin
      if (acc) begin
        m_v     = 1'b1;
        m_idpc  = m_pc;
        m_instr = mem(m_pc);
      end else begin
        e.pc    = m_pc;
        e.instr = mem(m_pc);
        skid.push_back(e);
      end
      m_pc = npc;
    end else if (acc) begin
      m_v = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("pc_out", pc_out, m_pc);
    chk("pcplus4", pcplus4, m_pc + 32'd4);
    chk("imem_req", {31'h0, bus.req}, {31'h0, skid.size() == 0});
    chk("imem_addr", bus.addr, m_dropping ? m_drop_addr : m_pc);
    chk("id_valid", {31'h0, id_valid}, {31'h0, m_v});
    if (m_v) chk("id_pc", id_pc, m_idpc);
    chk("id_instr", id_instr, m_instr);
  endtask

  task automatic drive(input logic rdy, input logic st, input logic rd, input logic [31:0] tgt);
    bus.ready = rdy;
    stall     = st;
    redirect  = rd;
    npc       = rd ? tgt : m_pc + 32'd4;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, {31'h0, bus.req}, 32'd1);
    chk({tag, "_addr"}, bus.addr, 32'h0);
    chk({tag, "_pc_out"}, pc_out, 32'h0);
    chk({tag, "_pcplus4"}, pcplus4, 32'h4);
    chk({tag, "_valid"}, {31'h0, id_valid}, 32'd0);
    chk({tag, "_instr"}, id_instr, NOP);
  endtask

  initial begin
    logic [31:0] tgt;
    bus.ready = 1'b1;
    model_reset();
    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    rst = 1'b0;
    compare();

    // Zero-wait streaming
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      step();
      chk("seq_addr", bus.addr, 32'(4 * k));
      chk("seq_id_pc", id_pc, 32'(4 * (k - 1)));
      chk("seq_instr", id_instr, mem(32'(4 * (k - 1))));
    end

    // Stall three cycles: one fetch (0xc) goes to skid, IF/ID frozen at 0x8
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      step();
      chk("stall_req", {31'h0, bus.req}, 32'd0);
      chk("stall_id_pc", id_pc, 32'h8);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    chk("release_id_pc", id_pc, 32'hc);
    chk("release_addr", bus.addr, 32'h10);

    // Two wait states at 0x10
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      step();
      chk("wait_addr", bus.addr, 32'h10);
      chk("wait_valid", {31'h0, id_valid}, 32'd0);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    chk("wait_done_id_pc", id_pc, 32'h10);

    // Redirect while 0x14 is outstanding
    drive(1'b0, 1'b0, 1'b1, 32'h100);
    step();
    chk("drop_addr", bus.addr, 32'h14);
    chk("drop_pc_out", pc_out, 32'h100);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("drop_addr2", bus.addr, 32'h14);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    chk("after_drop_addr", bus.addr, 32'h100);
    chk("after_drop_valid", {31'h0, id_valid}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    chk("target_id_pc", id_pc, 32'h100);

    // Redirect together with stall while holding a skid entry
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    chk("hold_req", {31'h0, bus.req}, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'h200);
    step();
    chk("rs_valid", {31'h0, id_valid}, 32'd0);
    chk("rs_instr", id_instr, NOP);
    chk("rs_pc_out", pc_out, 32'h200);
    chk("rs_addr", bus.addr, 32'h200);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    chk("rs_next_id_pc", id_pc, 32'h200);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step();

    // Asynchronous reset in the middle of a stall
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, tgt);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
